// File: rtl/mem_store_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_store_ctrl_if
// Bundles the two handshakes around the store sequencer:
//   store side : st_valid/st_ready request, st_addr/st_data/st_func3 payload,
//                st_done/st_err completion pulses
//   memory side: mem_req/mem_gnt write handshake, mem_addr (word aligned),
//                mem_wmask byte enables, mem_wdata lane-aligned data
// Modports:
//   master : the environment (core store port plus data memory) that drives
//            requests and grants into the sequencer
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface mem_store_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [2:0]        st_func3;
    logic              st_done;
    logic              st_err;

    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;

    modport master (
        output st_valid, st_addr, st_data, st_func3, mem_gnt,
        input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wmask, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_func3, mem_gnt,
        output st_ready, st_done, st_err, mem_req, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/mem_store_ctrl.sv
// -----------------------------------------------------------------------------
// mem_store_ctrl
// Store sequencer between the core store port and a byte-write data memory.
// Takes one SB/SH/SW request at a time, turns it into word-aligned writes with
// byte masks and lane-shifted data, splits word-crossing stores into a LO and
// a HI write, and answers with a one-cycle st_done or st_err pulse.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_store_ctrl_if.slave (store request/response + memory write)
// Parameters:
//   ADDR_W         : byte address width, memory addresses wrap modulo 2^ADDR_W
//   ALLOW_MISALIGN : 1 = split word-crossing stores, 0 = reject them
// -----------------------------------------------------------------------------
module mem_store_ctrl #(
    parameter int ADDR_W         = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    mem_store_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [2:0]        func3_q;

    // Decoder inputs: live request while idle (the exit decision is taken on
    // the accepting edge), latched request afterwards.
    logic [ADDR_W-1:0] dec_addr;
    logic [31:0]       dec_data;
    logic [2:0]        dec_func3;
    logic              legal;
    logic [3:0]        size_mask;
    logic [31:0]       data_kept;
    logic [7:0]        m8;
    logic [63:0]       d64;
    logic [3:0]        lo_mask;
    logic [3:0]        hi_mask;
    logic              split;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;

    logic              accept;
    logic              ready_d;
    logic              done_d;
    logic              err_d;
    logic              req_d;
    logic [ADDR_W-1:0] maddr_d;
    logic [3:0]        wmask_d;
    logic [31:0]       wdata_d;

    assign accept = (state_q == S_IDLE) && bus.st_valid;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        dec_addr  = (state_q == S_IDLE) ? bus.st_addr  : addr_q;
        dec_data  = (state_q == S_IDLE) ? bus.st_data  : data_q;
        dec_func3 = (state_q == S_IDLE) ? bus.st_func3 : func3_q;
        legal     = 1'b1;
        size_mask = 4'b0000;
        data_kept = 32'h0;
        unique case (dec_func3)
            3'b000: begin
                size_mask = 4'b0001;
                data_kept = {24'h0, dec_data[7:0]};
            end
            3'b001: begin
                size_mask = 4'b0011;
                data_kept = {16'h0, dec_data[15:0]};
            end
            3'b010: begin
                size_mask = 4'b1111;
                data_kept = dec_data;
            end
            default: legal = 1'b0;
        endcase
        m8      = {4'b0000, size_mask} << dec_addr[1:0];
        d64     = {32'h0, data_kept} << {dec_addr[1:0], 3'b000};
        lo_mask = m8[3:0];
        hi_mask = m8[7:4];
        split   = |hi_mask;
        lo_addr = {dec_addr[ADDR_W-1:2], 2'b00};
        hi_addr = lo_addr + ADDR_W'(4);   // wraps modulo 2^ADDR_W
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the request payload is deliberately not reset; it is only read in
    // LO/HI, which are reachable solely through an accept that loads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.st_addr;
            data_q  <= bus.st_data;
            func3_q <= bus.st_func3;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        req_d   = 1'b0;
        maddr_d = '0;
        wmask_d = 4'b0000;
        wdata_d = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.st_valid) begin
                    if (!legal || (split && !ALLOW_MISALIGN)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                req_d   = 1'b1;
                maddr_d = lo_addr;
                wmask_d = lo_mask;
                wdata_d = d64[31:0];
                if (bus.mem_gnt) begin
                    state_d = split ? S_HI : S_DONE;
                end
            end
            S_HI: begin
                req_d   = 1'b1;
                maddr_d = hi_addr;
                wmask_d = hi_mask;
                wdata_d = d64[63:32];
                if (bus.mem_gnt) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is masked while reset is held so the requester never sees the
    // sequencer as available before the reset edge has been taken.
    assign bus.st_ready  = ready_d && !rst;
    assign bus.st_done   = done_d;
    assign bus.st_err    = err_d;
    assign bus.mem_req   = req_d;
    assign bus.mem_addr  = maddr_d;
    assign bus.mem_wmask = wmask_d;
    assign bus.mem_wdata = wdata_d;
endmodule

// File: doc/mem_store_ctrl.md
Name: mem_store_ctrl

Overview:
Store sequencer between the core's store port and the byte-write data memory.
- Accepts one store request at a time: address, data and func3 (SB/SH/SW).
- Generates word-aligned memory writes with byte write masks and lane-shifted write data.
- Splits misaligned stores that cross a word boundary into two back-to-back word writes.
- Uses a req/gnt handshake on the memory side and reports completion or error to the requester.

Parameters:
ADDR_W, 32, byte address width; memory addresses wrap modulo 2^ADDR_W.
ALLOW_MISALIGN, 1, 1 = split word-crossing stores; 0 = reject them with st_err.

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous active-high reset
st_valid  in  1  store request valid
st_ready  out  1  controller can accept a request (high only in IDLE)
st_addr  in  ADDR_W  byte address of store
st_data  in  32  store data, LSB-justified
st_func3  in  3  000 SB, 001 SH, 010 SW; all other codes illegal
st_done  out  1  one-cycle pulse: all writes of the store have been granted
st_err  out  1  one-cycle pulse: store rejected, no memory write issued
mem_req  out  1  memory write request
mem_gnt  in  1  memory accepts current write when mem_req && mem_gnt
mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00
mem_wmask  out  4  byte write enables; bit i enables byte lane i
mem_wdata  out  32  lane-aligned write data

Behaviour:
- Reset values: st_ready=0 during reset, then 1 in IDLE. st_done=0, st_err=0, mem_req=0, mem_addr=0, mem_wmask=0, mem_wdata=0. The FSM enters IDLE.
- States: IDLE, LO, HI, DONE, ERR.
- IDLE:
  - st_ready=1.
  - On st_valid, latch addr, data and func3 in the same cycle; st_ready drops on the next cycle.
- Decode of the latched request:
  - size = 1/2/4 bytes for func3 000/001/010.
  - off = addr[1:0].
  - m8 = 8-bit mask (2^size - 1) << off.
  - d64 = {32'b0, data} << (8*off).
  - lo_mask = m8[3:0], hi_mask = m8[7:4], split = (hi_mask != 0).
  - Unused data bits above size are zeroed before shifting: SB keeps data[7:0], SH keeps data[15:0].
- IDLE exit:
  - Illegal func3 goes to ERR.
  - split with ALLOW_MISALIGN=0 goes to ERR.
  - Otherwise go to LO.
- LO:
  - mem_req=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wmask=lo_mask, mem_wdata=d64[31:0].
  - On mem_gnt go to HI if split, else DONE.
- HI:
  - mem_req=1, mem_addr = LO word address + 4 (wraps modulo 2^ADDR_W), mem_wmask=hi_mask, mem_wdata=d64[63:32].
  - On mem_gnt go to DONE.
- Holding rule: while mem_req=1 && mem_gnt=0, mem_addr, mem_wmask and mem_wdata stay stable. mem_req never deasserts before a grant.
- DONE: st_done=1 for exactly one cycle, mem_req=0, then go to IDLE.
- ERR: st_err=1 for exactly one cycle, mem_req=0, no write issued, then go to IDLE.
- When mem_req=0, mem_wmask=0; mem_addr and mem_wdata are don't-care.
- Latency (mem_gnt tied high, request accepted at edge 0):
  - aligned: mem_req in cycle 1, st_done in cycle 2.
  - split: LO write in cycle 1, HI write in cycle 2, st_done in cycle 3.
  - error: st_err in cycle 1.
- Back-to-back: a new request is accepted in the cycle after the done/err pulse, when the FSM is back in IDLE. Maximum throughput is one aligned store per 3 cycles.
- Inputs st_addr, st_data and st_func3 may change after acceptance without effect.
- Reset mid-operation: at the reset edge mem_req drops and the FSM enters IDLE. No st_done is produced; a partially issued split store is abandoned.
- SW at off=0 and SH at off≤2 never split. SB never splits.

Test Plan:
- SB, data 0x12345678, addr 0x1001, gnt=1 -> mem_addr 0x1000, wmask 0010, wdata 0x00007800, single write, st_done in cycle 2.
- SH, data 0x12345678, addr 0x1003 -> two writes:
  - 0x1000, wmask 1000, wdata 0x78000000;
  - 0x1004, wmask 0001, wdata 0x00000056;
  - st_done in cycle 3.
- SW, data 0x12345678, addr 0x2002, gnt low for 3 cycles then high -> write 0x2000, wmask 1100, wdata 0x56780000 held stable 4 cycles; then write 0x2004, wmask 0011, wdata 0x00001234.
- SW at addr 0xFFFFFFFF -> second write to 0x00000000, wmask 0111, wdata 0x00123456. With ALLOW_MISALIGN=0 the same store gives st_err and no mem_req.
- func3=011 and func3=100 -> st_err pulse in cycle 1, mem_req never asserted, st_ready high again in cycle 2.
- Split SW in progress, rst asserted during HI -> mem_req=0 after the edge, no st_done, st_ready=1 after rst deasserts; a following aligned SW completes normally.
